keypad_entry: RTL and testbench

Keypad front-end that collects decimal digit keystrokes into the 12-bit `passin` code and issues the one-cycle `enter` strobe consumed by the door security checker. It is the producer side of the `passin`/`enter` interface: it handles digit shifting, backspace, clear, incomplete-entry rejection, alarm lockout and an optional inter-key timeout. It sits between the keypad scanner/debouncer and `door_security`.

---
 rtl/keypad_entry.sv | 171 +++++++++++++++++
 tb/tb_keypad_entry.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry.sv
// keypad_entry
// Keypad front-end for the door security checker. It collects decimal digit
// keystrokes into a DIGITS-wide BCD code and issues a one-cycle submit strobe.
// It also handles backspace, clear, rejection of incomplete entries, alarm
// lockout and an optional inter-key timeout.
//
// Optional feature macro: KEYPAD_TIMEOUT_EN
//   defined   -> a partial entry is discarded after TIMEOUT idle cycles
//   undefined -> no timer; partial entries persist; timeout tied to 0
//
// Ports:
//   clk        in   single clock, rising edge
//   reset      in   synchronous active-high reset, dominates all inputs
//   key_valid  in   one-cycle qualifier for key_code
//   key_code   in   0-9 digit, A clear, B backspace, E enter, C/D/F ignored
//   lockout    in   alarm from the checker; keys ignored and entry flushed
//   passin     out  assembled code, most recent digit in [3:0]
//   enter      out  one-cycle submit strobe
//   digits     out  number of digits currently held
//   err        out  one-cycle pulse on a rejected enter
//   timeout    out  one-cycle pulse when a partial entry expires
//
// State table:
//   S_IDLE   | no digits held
//   S_ENTRY  | 0 < digits < DIGITS
//   S_FULL   | digits == DIGITS, waiting for enter
//   S_SUBMIT | the single cycle with enter high

module keypad_entry #(
    parameter int DIGITS  = 3,
    parameter int TIMEOUT = 1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                key_valid,
    input  logic [3:0]          key_code,
    input  logic                lockout,
    output logic [DIGITS*4-1:0] passin,
    output logic                enter,
    output logic [1:0]          digits,
    output logic                err,
    output logic                timeout
);

    localparam int         W    = DIGITS * 4;
    localparam logic [1:0] DMAX = 2'(DIGITS);

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("keypad_entry: TIMEOUT must be at least 2");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ENTRY,
        S_FULL,
        S_SUBMIT
    } state_t;

    state_t       state_q;
    logic [W-1:0] passin_q;
    logic [1:0]   digits_q;
    logic         enter_q;
    logic         err_q;

    logic key_digit;
    logic key_bksp;
    logic key_clear;
    logic key_enter;

    assign key_digit = key_valid && (key_code <= 4'h9) && (digits_q != DMAX);
    assign key_bksp  = key_valid && (key_code == 4'hB) && (digits_q != 2'd0);
    assign key_clear = key_valid && (key_code == 4'hA);
    assign key_enter = key_valid && (key_code == 4'hE);

`ifdef KEYPAD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT);
    logic [TW-1:0] timer_q;
    logic          timeout_q;
`endif

    always_ff @(posedge clk) begin
        enter_q <= 1'b0;
        err_q   <= 1'b0;
`ifdef KEYPAD_TIMEOUT_EN
        timeout_q <= 1'b0;
`endif
        if (reset) begin
            state_q  <= S_IDLE;
            passin_q <= '0;
            digits_q <= 2'd0;
`ifdef KEYPAD_TIMEOUT_EN
            timer_q  <= '0;
`endif
        end else if (state_q == S_SUBMIT) begin
            // The submit cycle always completes; keys and lockout are not
            // looked at until the entry has been flushed.
            state_q  <= S_IDLE;
            passin_q <= '0;
            digits_q <= 2'd0;
`ifdef KEYPAD_TIMEOUT_EN
            timer_q  <= '0;
`endif
        end else if (lockout) begin
            state_q  <= S_IDLE;
            passin_q <= '0;
            digits_q <= 2'd0;
`ifdef KEYPAD_TIMEOUT_EN
            timer_q  <= '0;
`endif
        end else if (key_digit) begin
            passin_q <= {passin_q[W-5:0], key_code};
            digits_q <= digits_q + 2'd1;
            state_q  <= ((digits_q + 2'd1) == DMAX) ? S_FULL : S_ENTRY;
`ifdef KEYPAD_TIMEOUT_EN
            timer_q  <= '0;
`endif
        end else if (key_bksp) begin
            passin_q <= passin_q >> 4;
            digits_q <= digits_q - 2'd1;
            state_q  <= (digits_q == 2'd1) ? S_IDLE : S_ENTRY;
`ifdef KEYPAD_TIMEOUT_EN
            timer_q  <= '0;
`endif
        end else if (key_clear) begin
            state_q  <= S_IDLE;
            passin_q <= '0;
            digits_q <= 2'd0;
`ifdef KEYPAD_TIMEOUT_EN
            timer_q  <= '0;
`endif
        end else if (key_enter) begin
            if (state_q == S_FULL) begin
                state_q <= S_SUBMIT;
                enter_q <= 1'b1;
            end else begin
                state_q  <= S_IDLE;
                passin_q <= '0;
                digits_q <= 2'd0;
                err_q    <= 1'b1;
            end
`ifdef KEYPAD_TIMEOUT_EN
            timer_q  <= '0;
`endif
        end
`ifdef KEYPAD_TIMEOUT_EN
        // Only reached with no accepted key: ignored codes let the timer run.
        else if (state_q != S_IDLE) begin
            if (timer_q == TW'(TIMEOUT - 1)) begin
                state_q   <= S_IDLE;
                passin_q  <= '0;
                digits_q  <= 2'd0;
                timer_q   <= '0;
                timeout_q <= 1'b1;
            end else begin
                timer_q <= timer_q + TW'(1);
            end
        end
`endif
    end

    assign passin = passin_q;
    assign digits = digits_q;
    assign enter  = enter_q;
    assign err    = err_q;
`ifdef KEYPAD_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_entry.sv
module tb_keypad_entry;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic        lockout = 1'b0;
    logic [11:0] passin;
    logic        enter;
    logic [1:0]  digits;
    logic        err;
    logic        timeout;

    keypad_entry #(.DIGITS(3), .TIMEOUT(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .key_valid (key_valid),
        .key_code  (key_code),
        .lockout   (lockout),
        .passin    (passin),
        .enter     (enter),
        .digits    (digits),
        .err       (err),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] p;
        logic [1:0]  d;
        logic        en;
        logic        er;
        logic        to;
    } exp_t;

    exp_t sb_q[$];

    int n_chk  = 0;
    int n_pass = 0;

    // reference model state
    logic [11:0] m_p;
    logic [1:0]  m_d;
    logic        m_sub;
    int          m_t;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Drive one cycle of inputs, predict the outputs after the next edge,
    // then compare once the DUT has produced them.
    task automatic step(input logic kv, input logic [3:0] kc,
                        input logic lk = 1'b0, input logic rs = 1'b0);
        exp_t e;
        exp_t o;
        logic acc;
        reset     = rs;
        key_valid = kv;
        key_code  = kc;
        lockout   = lk;
        e   = '0;
        acc = 1'b0;
        if (rs || m_sub) begin
            m_p = '0; m_d = 2'd0; m_sub = 1'b0; m_t = 0;
        end else if (lk) begin
            m_p = '0; m_d = 2'd0; m_t = 0;
        end else begin
            if (kv) begin
                if (kc <= 4'd9) begin
                    if (m_d < 2'd3) begin
                        m_p = {m_p[7:0], kc};
                        m_d = m_d + 2'd1;
                        acc = 1'b1;
                    end
                end else if (kc == 4'hB) begin
                    if (m_d != 2'd0) begin
                        m_p = m_p >> 4;
                        m_d = m_d - 2'd1;
                        acc = 1'b1;
                    end
                end else if (kc == 4'hA) begin
                    if (m_d != 2'd0) acc = 1'b1;
                    m_p = '0;
                    m_d = 2'd0;
                end else if (kc == 4'hE) begin
                    acc = 1'b1;
                    if (m_d == 2'd3) begin
                        m_sub = 1'b1;
                        e.en  = 1'b1;
                    end else begin
                        e.er = 1'b1;
                        m_p  = '0;
                        m_d  = 2'd0;
                    end
                end
            end
            if (acc) m_t = 0;
`ifdef KEYPAD_TIMEOUT_EN
            else if (m_d != 2'd0) begin
                if (m_t == 7) begin
                    m_p = '0; m_d = 2'd0; m_t = 0;
                    e.to = 1'b1;
                end else begin
                    m_t = m_t + 1;
                end
            end
`endif
        end
        e.p = m_p;
        e.d = m_d;
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        o = sb_q.pop_front();
        chk("sb_passin",  32'(passin),  32'(o.p));
        chk("sb_digits",  32'(digits),  32'(o.d));
        chk("sb_enter",   32'(enter),   32'(o.en));
        chk("sb_err",     32'(err),     32'(o.er));
        chk("sb_timeout", 32'(timeout), 32'(o.to));
    endtask

    task automatic key(input logic [3:0] kc);
        step(1'b1, kc);
    endtask

    task automatic idle();
        step(1'b0, 4'h0);
    endtask

    initial begin
        m_p = '0; m_d = 2'd0; m_sub = 1'b0; m_t = 0;

        step(1'b0, 4'h0, 1'b0, 1'b1);
        step(1'b0, 4'h0, 1'b0, 1'b1);
        chk("rst_passin", 32'(passin), 32'h0);
        chk("rst_digits", 32'(digits), 32'h0);
        chk("rst_enter",  32'(enter),  32'h0);
        chk("rst_err",    32'(err),    32'h0);
        idle();

        // 1,2,3,E
        key(4'h1); key(4'h2); key(4'h3);
        chk("t1_digits_full", 32'(digits), 32'd3);
        key(4'hE);
        chk("t1_enter",  32'(enter),  32'h1);
        chk("t1_passin", 32'(passin), 32'h123);
        idle();
        chk("t1_enter_off", 32'(enter),  32'h0);
        chk("t1_flushed",   32'(passin), 32'h0);
        chk("t1_dig0",      32'(digits), 32'h0);

        // 4,5,B,6,7,E
        key(4'h4); chk("t2_a", 32'(passin), 32'h004);
        key(4'h5); chk("t2_b", 32'(passin), 32'h045);
        key(4'hB); chk("t2_c", 32'(passin), 32'h004);
        key(4'h6); chk("t2_d", 32'(passin), 32'h046);
        key(4'h7); chk("t2_e", 32'(passin), 32'h467);
        key(4'hE);
        chk("t2_enter",  32'(enter),  32'h1);
        chk("t2_passin", 32'(passin), 32'h467);
        idle();

        // 9,E rejected; then 1,2,3,4 with 4 ignored
        key(4'h9); key(4'hE);
        chk("t3_err",    32'(err),    32'h1);
        chk("t3_enter",  32'(enter),  32'h0);
        chk("t3_passin", 32'(passin), 32'h0);
        idle();
        chk("t3_err_off", 32'(err), 32'h0);
        key(4'h1); key(4'h2); key(4'h3); key(4'h4);
        chk("t3_full_code", 32'(passin), 32'h123);
        chk("t3_full_dig",  32'(digits), 32'd3);
        key(4'hA);
        chk("t3_clear", 32'(digits), 32'd0);

        // lockout
        key(4'h1); key(4'h2);
        step(1'b1, 4'h3, 1'b1);
        step(1'b1, 4'hE, 1'b1);
        chk("t4_lock_passin", 32'(passin), 32'h0);
        chk("t4_lock_digits", 32'(digits), 32'h0);
        chk("t4_lock_enter",  32'(enter),  32'h0);
        idle();
        key(4'h7); key(4'h8); key(4'h9); key(4'hE);
        chk("t4_enter",  32'(enter),  32'h1);
        chk("t4_passin", 32'(passin), 32'h789);
        idle();

        // reset coinciding with a key
        key(4'h1); key(4'h2);
        step(1'b1, 4'h3, 1'b0, 1'b1);
        chk("t5_passin", 32'(passin), 32'h0);
        chk("t5_digits", 32'(digits), 32'h0);
        idle();

        // ignored codes, backspace in IDLE, key during SUBMIT, lockout during SUBMIT
        key(4'hC); key(4'hD); key(4'hF); key(4'hB);
        chk("t6_ignored", 32'(digits), 32'h0);
        key(4'h1); key(4'h2); key(4'h3); key(4'hB);
        chk("t6_bksp_full", 32'(passin), 32'h012);
        key(4'h4); key(4'hE);
        chk("t6_code", 32'(passin), 32'h124);
        key(4'h5);
        chk("t6_submit_key", 32'(passin), 32'h0);
        key(4'h1); key(4'h2); key(4'h3); key(4'hE);
        step(1'b0, 4'h0, 1'b1);
        step(1'b0, 4'h0, 1'b1);
        idle();

`ifdef KEYPAD_TIMEOUT_EN
        key(4'h5);
        for (int i = 0; i < 7; i++) idle();
        chk("t7_to_early", 32'(timeout), 32'h0);
        idle();
        chk("t7_to_pulse",  32'(timeout), 32'h1);
        chk("t7_to_passin", 32'(passin),  32'h0);
        idle();
        chk("t7_to_off", 32'(timeout), 32'h0);
        key(4'h5);
        for (int i = 0; i < 5; i++) idle();
        key(4'h6);
        for (int i = 0; i < 7; i++) idle();
        chk("t7_no_to",   32'(timeout), 32'h0);
        chk("t7_kept",    32'(passin),  32'h056);
        key(4'hA);
`else
        key(4'h5);
        for (int i = 0; i < 20; i++) idle();
        chk("t7_persist", 32'(passin),  32'h005);
        chk("t7_no_to",   32'(timeout), 32'h0);
        key(4'hA);
`endif

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 11) == 0),
                 1'($urandom_range(0, 59) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
